// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - per-frame sprite position update (auto-bounce / manual)
module sprite_motion_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPRITE_SIZE = 64,
  parameter int STEP        = 2,
  parameter int INIT_X      = 288,
  parameter int INIT_Y      = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic       mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce,
  output logic [7:0] frame_cnt
);

  localparam int XMAX = H_ACTIVE - SPRITE_SIZE;
  localparam int YMAX = V_ACTIVE - SPRITE_SIZE;
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XMAX_S = 11'(XMAX);
  localparam logic signed [10:0] YMAX_S = 11'(YMAX);

  typedef enum logic [1:0] {S_WAIT, S_CALC, S_COMMIT} state_t;

  state_t     state;
  logic       smode, sleft, sright, sup, sdown;
  logic [9:0] nx, ny;
  logic       ndx, ndy, nbounce;
  logic [11:0] step_x, step_y;

  // One axis update: returns {new_pos, new_dir, bounced}; all math in 11-bit signed
  // so a step past either edge is clamped before it is cut back to 10 bits.
  function automatic logic [11:0] axis_step(
    input logic [9:0]        pos,
    input logic              dir,
    input logic              man,
    input logic              inc,
    input logic              dec,
    input logic signed [10:0] lim
  );
    logic signed [10:0] p;
    logic signed [10:0] up;
    logic signed [10:0] dn;
    logic [9:0]         np;
    logic               nd;
    logic               b;
    p  = signed'({1'b0, pos});
    up = p + STEP_S;
    dn = p - STEP_S;
    np = pos;
    nd = dir;
    b  = 1'b0;
    if (man) begin
      if (inc && !dec) begin
        np = (up >= lim) ? lim[9:0] : up[9:0];
        nd = 1'b0;
      end else if (dec && !inc) begin
        np = (dn <= 11'sd0) ? 10'd0 : dn[9:0];
        nd = 1'b1;
      end
    end else if (!dir) begin
      if (up >= lim) begin
        np = lim[9:0];
        nd = 1'b1;
        b  = 1'b1;
      end else begin
        np = up[9:0];
      end
    end else begin
      if (dn <= 11'sd0) begin
        np = 10'd0;
        nd = 1'b0;
        b  = 1'b1;
      end else begin
        np = dn[9:0];
      end
    end
    return {np, nd, b};
  endfunction

  // Candidate next values for both axes from the inputs latched at the accepted tick
  always_comb begin
    step_x = axis_step(posx, dir_x, smode, sright, sleft, XMAX_S);
    step_y = axis_step(posy, dir_y, smode, sdown, sup, YMAX_S);
  end

  // Frame update sequencer: latch inputs, compute, then commit to the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      smode     <= 1'b0;
      sleft     <= 1'b0;
      sright    <= 1'b0;
      sup       <= 1'b0;
      sdown     <= 1'b0;
      nx        <= 10'(INIT_X);
      ny        <= 10'(INIT_Y);
      ndx       <= 1'b0;
      ndy       <= 1'b0;
      nbounce   <= 1'b0;
      posx      <= 10'(INIT_X);
      posy      <= 10'(INIT_Y);
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      bounce    <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      bounce <= 1'b0;
      case (state)
        S_WAIT: begin
          if (frame_tick && !pause) begin
            smode  <= mode;
            sleft  <= btn_left;
            sright <= btn_right;
            sup    <= btn_up;
            sdown  <= btn_down;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          nx      <= step_x[11:2];
          ndx     <= step_x[1];
          ny      <= step_y[11:2];
          ndy     <= step_y[1];
          nbounce <= step_x[0] | step_y[0];
          state   <= S_COMMIT;
        end
        S_COMMIT: begin
          posx      <= nx;
          posy      <= ny;
          dir_x     <= ndx;
          dir_y     <= ndy;
          bounce    <= nbounce;
          frame_cnt <= frame_cnt + 8'd1;
          state     <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - self-checking bench for sprite_motion_ctrl
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [9:0] posx, posy;
  logic       dir_x, dir_y, bounce;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  sprite_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause), .mode(mode),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .posx(posx), .posy(posy), .dir_x(dir_x), .dir_y(dir_y), .bounce(bounce),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  localparam int XMAX = 576;
  localparam int YMAX = 416;
  localparam int STEP = 2;

  // Reference model: visible state plus a pending update that lands two edges after acceptance
  int mx = 288, my = 208, mdx = 0, mdy = 0, mcnt = 0, mb = 0;
  int px, py, pdx, pdy, pb;
  int busy = 0;

  task automatic move(input int pos, input int dir, input int man, input int inc, input int dec,
                      input int lim, output int npos, output int ndir, output int hit);
    npos = pos; ndir = dir; hit = 0;
    if (man != 0) begin
      if (inc != 0 && dec == 0) begin
        npos = (pos + STEP > lim) ? lim : pos + STEP; ndir = 0;
      end else if (dec != 0 && inc == 0) begin
        npos = (pos - STEP < 0) ? 0 : pos - STEP; ndir = 1;
      end
    end else if (dir == 0) begin
      if (pos + STEP >= lim) begin npos = lim; ndir = 1; hit = 1; end
      else npos = pos + STEP;
    end else begin
      if (pos - STEP <= 0) begin npos = 0; ndir = 0; hit = 1; end
      else npos = pos - STEP;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int hx, hy;
    if (!rst_n) begin
      mx = 288; my = 208; mdx = 0; mdy = 0; mcnt = 0; mb = 0; busy = 0;
    end else begin
      mb = 0;
      if (busy > 0) begin
        busy = busy - 1;
        if (busy == 0) begin
          mx = px; my = py; mdx = pdx; mdy = pdy; mb = pb;
          mcnt = (mcnt + 1) % 256;
        end
      end else if (frame_tick && !pause) begin
        move(mx, mdx, int'(mode), int'(btn_right), int'(btn_left), XMAX, px, pdx, hx);
        move(my, mdy, int'(mode), int'(btn_down), int'(btn_up), YMAX, py, pdy, hy);
        pb = (hx != 0 || hy != 0) ? 1 : 0;
        busy = 2;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    checks++;
    if (int'(posx) != mx || int'(posy) != my || int'(dir_x) != mdx || int'(dir_y) != mdy ||
        int'(bounce) != mb || int'(frame_cnt) != mcnt) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got x=%0d y=%0d dx=%0d dy=%0d b=%0d cnt=%0d want x=%0d y=%0d dx=%0d dy=%0d b=%0d cnt=%0d",
               $time, posx, posy, dir_x, dir_y, bounce, frame_cnt, mx, my, mdx, mdy, mb, mcnt);
    end
  end

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  int last_bounce;

  // One accepted tick with given mode/buttons; returns after the commit with bounce sampled
  task automatic tick(input logic m, input logic l, input logic r, input logic u, input logic d);
    @(posedge clk); #1;
    mode = m; btn_left = l; btn_right = r; btn_up = u; btn_down = d;
    pause = 1'b0; frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    last_bounce = int'(bounce);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("reset_posx", int'(posx), 288);
    lit("reset_posy", int'(posy), 208);
    lit("reset_dir", int'({dir_x, dir_y}), 0);
    lit("reset_cnt", int'(frame_cnt), 0);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    lit("idle_posx", int'(posx), 288);
    lit("idle_cnt", int'(frame_cnt), 0);

    // First auto step, with a second tick one cycle later that must be dropped
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    lit("step_posx", int'(posx), 290);
    lit("step_posy", int'(posy), 210);
    lit("step_cnt", int'(frame_cnt), 1);

    // Walk right until 574, then bounce off the right edge
    while (posx != 10'd574) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("pre_bounce_dir", int'(dir_x), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("bounce_posx", int'(posx), 576);
    lit("bounce_dirx", int'(dir_x), 1);
    lit("bounce_pulse", last_bounce, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("after_bounce_posx", int'(posx), 574);

    // Manual: steer to x=2 moving left, y=414 moving down, then corner in auto
    rst_n = 1'b0; #3; rst_n = 1'b1;
    repeat (103) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (40) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("man_posx", int'(posx), 2);
    lit("man_posy", int'(posy), 414);
    lit("man_dirs", int'({dir_x, dir_y}), 2);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("corner_posx", int'(posx), 0);
    lit("corner_posy", int'(posy), 416);
    lit("corner_dirs", int'({dir_x, dir_y}), 1);
    lit("corner_bounce", last_bounce, 1);

    // Manual saturation at the left edge
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("man_right", int'(posx), 2);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("sat_posx", int'(posx), 0);
    lit("sat_dirx", int'(dir_x), 1);
    lit("sat_bounce", last_bounce, 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("sat_hold", int'(posx), 0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    lit("both_btn", int'(posx), 0);
    lit("both_dir", int'(dir_x), 1);

    // Pause: ticks ignored
    @(posedge clk); #1;
    pause = 1'b1;
    repeat (5) begin
      frame_tick = 1'b1; @(posedge clk); #1;
      frame_tick = 1'b0; repeat (3) @(posedge clk); #1;
    end
    pause = 1'b0;
    lit("pause_cnt", int'(frame_cnt), 148);

    // Reset during the calc cycle discards the update
    frame_tick = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lit("midrst_posx", int'(posx), 288);
    lit("midrst_posy", int'(posy), 208);
    lit("midrst_cnt", int'(frame_cnt), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      frame_tick = ($urandom_range(0, 2) == 0);
      pause = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 40) == 0) mode = ~mode;
      btn_left = $urandom_range(0, 1) == 1;
      btn_right = $urandom_range(0, 1) == 1;
      btn_up = $urandom_range(0, 1) == 1;
      btn_down = $urandom_range(0, 1) == 1;
      rst_n = ($urandom_range(0, 700) != 0);
    end
    rst_n = 1'b1;
    frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
